// File: rtl/lsu_mem_initiator.sv
// Single-outstanding LSU-to-scratchpad request initiator: accepts one load/store/CAS,
// issues a one-cycle mem_req, waits for mem_ready with timeout, returns tagged result.
module lsu_mem_initiator #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_we,
  input  logic             op_atomic,
  input  logic             op_signed,
  input  logic [1:0]       op_size,
  input  logic [XLEN-1:0]  op_addr,
  input  logic [XLEN-1:0]  op_wdata,
  input  logic [XLEN-1:0]  op_cmp_val,
  input  logic [TAG_W-1:0] op_tag,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_atomic,
  output logic [1:0]       mem_size,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [XLEN-1:0]  mem_cmp_val,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_error,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [XLEN-1:0]  res_data,
  output logic [1:0]       res_exc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req_we;
  logic               req_atomic;
  logic               req_signed;
  logic [1:0]         req_size;
  logic [XLEN-1:0]    req_addr;
  logic [XLEN-1:0]    req_wdata;
  logic [XLEN-1:0]    req_cmp_val;
  logic [TAG_W-1:0]   req_tag;

  // Selects the addressed lane of the raw word and extends it; CAS returns the old word.
  function automatic logic [XLEN-1:0] extract(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      size,
    input logic            sgn,
    input logic [1:0]      lane,
    input logic            we,
    input logic            atomic
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    res = '0;
    sh  = '0;
    if (atomic) begin
      res = rdata;
    end else if (we) begin
      res = '0;
    end else begin
      case (size)
        2'b00: begin
          sh  = rdata >> {lane, 3'b000};
          res = {{(XLEN-8){sgn & sh[7]}}, sh[7:0]};
        end
        2'b01: begin
          sh  = rdata >> {lane[1], 4'b0000};
          res = {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
        end
        2'b10:   res = rdata;
        default: res = '0;
      endcase
    end
    return res;
  endfunction

  assign mem_we      = req_we;
  assign mem_atomic  = req_atomic;
  assign mem_size    = req_size;
  assign mem_addr    = req_addr;
  assign mem_wdata   = req_wdata;
  assign mem_cmp_val = req_cmp_val;
  assign res_tag     = req_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_ready    <= 1'b0;
      mem_req     <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_exc     <= 2'b00;
      req_we      <= 1'b0;
      req_atomic  <= 1'b0;
      req_signed  <= 1'b0;
      req_size    <= 2'b00;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_cmp_val <= '0;
      req_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            op_ready    <= 1'b0;
            req_we      <= op_we;
            req_atomic  <= op_atomic;
            req_signed  <= op_signed;
            req_size    <= op_size;
            req_addr    <= op_addr;
            req_wdata   <= op_wdata;
            req_cmp_val <= op_cmp_val;
            req_tag     <= op_tag;
            // Illegal ops are answered directly without touching memory.
            if (op_size == 2'b11 || (op_atomic && op_size != 2'b10)) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_exc   <= 2'b11;
              res_data  <= '0;
            end else begin
              state   <= ISSUE;
              mem_req <= 1'b1;
            end
          end else begin
            op_ready <= 1'b1;
          end
        end
        ISSUE: begin
          mem_req <= 1'b0;
          if (mem_error) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_exc   <= 2'b01;
            res_data  <= '0;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_exc   <= 2'b00;
            res_data  <= extract(mem_rdata, req_size, req_signed, req_addr[1:0],
                                 req_we, req_atomic);
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_exc   <= 2'b10;
            res_data  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
          end else begin
            res_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          op_ready  <= 1'b0;
          mem_req   <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
